// File: rtl/attack_commit_ctrl.sv
// Attack-entry controller: debounces FIREBTN, latches COORD, filters repeat shots
// and tracks hits and game end. Optional shot budget enabled by `define SHOT_LIMIT_EN.
module attack_commit_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [63:0] SHIP_MAP        = 64'h0000_0000_0000_000F,
  parameter int unsigned SHIP_CELLS      = 4,
  parameter int unsigned MAX_SHOTS       = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] COORD,
  input  logic       FIREBTN,
  output logic       SHOTVALID,
  output logic       SHOTHIT,
  output logic       SHOTREPEAT,
  output logic [5:0] LASTCOORD,
  output logic [6:0] SHOTCOUNT,
  output logic [6:0] HITCOUNT,
  output logic       GAMEOVER,
  output logic       WIN,
  output logic [2:0] STATE_DBG
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS   = 3'd1,
    S_CHECK   = 3'd2,
    S_REPORT  = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] WIN_HITS = 7'(SHIP_CELLS);

  state_e      state_q;
  logic [1:0]  sync_q;
  logic [7:0]  cnt_q;
  logic [5:0]  coord_q;
  logic [63:0] bitmap_q;
  logic        valid_q, hit_q, rep_q, over_q, win_q;
  logic [5:0]  last_q;
  logic [6:0]  shots_q, hits_q;

  logic fs;
  logic win_now;
  logic limit_hit;

  assign fs      = sync_q[1];
  assign win_now = (hits_q == WIN_HITS);

`ifdef SHOT_LIMIT_EN
  assign limit_hit = (shots_q == 7'(MAX_SHOTS));
`else
  // No budget: MAX_SHOTS is legal only from 1 up, so this term is always 0.
  assign limit_hit = (MAX_SHOTS == 0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sync_q   <= 2'b00;
      cnt_q    <= 8'd0;
      coord_q  <= 6'd0;
      bitmap_q <= 64'd0;
      valid_q  <= 1'b0;
      hit_q    <= 1'b0;
      rep_q    <= 1'b0;
      last_q   <= 6'd0;
      shots_q  <= 7'd0;
      hits_q   <= 7'd0;
      over_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], FIREBTN};
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      rep_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fs) begin
            state_q <= S_PRESS;
            cnt_q   <= 8'd1;
          end
        end
        S_PRESS: begin
          if (!fs) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= S_CHECK;
            coord_q <= COORD;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_CHECK: begin
          state_q <= S_REPORT;
          if (bitmap_q[coord_q]) begin
            rep_q <= 1'b1;
          end else begin
            bitmap_q[coord_q] <= 1'b1;
            valid_q <= 1'b1;
            last_q  <= coord_q;
            if (shots_q != 7'd127) shots_q <= shots_q + 7'd1;
            if (SHIP_MAP[coord_q]) begin
              hit_q  <= 1'b1;
              hits_q <= hits_q + 7'd1;
            end
          end
        end
        S_REPORT: begin
          // Counts were updated on the CHECK edge, so they are current here.
          if (win_now) begin
            over_q  <= 1'b1;
            win_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (limit_hit) begin
            over_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RELEASE;
            cnt_q   <= 8'd0;
          end
        end
        S_RELEASE: begin
          if (fs) begin
            cnt_q <= 8'd0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign SHOTVALID  = valid_q;
  assign SHOTHIT    = hit_q;
  assign SHOTREPEAT = rep_q;
  assign LASTCOORD  = last_q;
  assign SHOTCOUNT  = shots_q;
  assign HITCOUNT   = hits_q;
  assign GAMEOVER   = over_q;
  assign WIN        = win_q;
  assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_attack_commit_ctrl.sv
// Directed bench for attack_commit_ctrl: debounce latency, glitch rejection,
// repeat filtering, win, shot budget and mid-flight reset.
module tb_attack_commit_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRESS = 3'd1;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] COORD = 6'd0;
  logic       FIREBTN = 1'b0;
  logic       SHOTVALID, SHOTHIT, SHOTREPEAT, GAMEOVER, WIN;
  logic [5:0] LASTCOORD;
  logic [6:0] SHOTCOUNT, HITCOUNT;
  logic [2:0] STATE_DBG;

  int tests_run = 0;
  int tests_failed = 0;

  attack_commit_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SHIP_MAP(64'h0000_0000_0000_000F),
    .SHIP_CELLS(4),
    .MAX_SHOTS(3)
  ) dut (
    .CLK(CLK), .RST(RST), .COORD(COORD), .FIREBTN(FIREBTN),
    .SHOTVALID(SHOTVALID), .SHOTHIT(SHOTHIT), .SHOTREPEAT(SHOTREPEAT),
    .LASTCOORD(LASTCOORD), .SHOTCOUNT(SHOTCOUNT), .HITCOUNT(HITCOUNT),
    .GAMEOVER(GAMEOVER), .WIN(WIN), .STATE_DBG(STATE_DBG)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    FIREBTN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  // Drivers: press and hold for 20 edges, recording any pulses seen.
  task automatic fire_obs(input logic [5:0] c, output logic v, output logic h,
                          output logic r, output int lat, output int npulse);
    v = 1'b0; h = 1'b0; r = 1'b0; lat = -1; npulse = 0;
    @(negedge CLK);
    COORD = c;
    FIREBTN = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge CLK);
      #1;
      if (SHOTVALID || SHOTREPEAT) begin
        npulse++;
        if (lat < 0) begin
          lat = e; v = SHOTVALID; h = SHOTHIT; r = SHOTREPEAT;
        end
      end
    end
  endtask

  task automatic release_btn();
    @(negedge CLK);
    FIREBTN = 1'b0;
    repeat (12) @(negedge CLK);
  endtask

  task automatic test_reset();
    tests_run++;
    if ({SHOTVALID, SHOTHIT, SHOTREPEAT, GAMEOVER, WIN} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_flags got %b exp 00000", {SHOTVALID, SHOTHIT, SHOTREPEAT, GAMEOVER, WIN});
    end
    tests_run++;
    if ({LASTCOORD, SHOTCOUNT, HITCOUNT} !== 20'd0) begin
      tests_failed++; $display("FAIL reset_counts got last=%0d shots=%0d hits=%0d exp 0", LASTCOORD, SHOTCOUNT, HITCOUNT);
    end
    tests_run++;
    if (STATE_DBG !== ST_IDLE) begin
      tests_failed++; $display("FAIL reset_state got %0d exp %0d", STATE_DBG, ST_IDLE);
    end
  endtask

  task automatic test_first_shot();
    logic v, h, r; int lat, np;
    fire_obs(6'd9, v, h, r, lat, np);
    tests_run++;
    if (lat !== 6) begin tests_failed++; $display("FAIL t1_latency got %0d exp 6", lat); end
    tests_run++;
    if ({v, h, r} !== 3'b100) begin tests_failed++; $display("FAIL t1_pulse got v/h/r=%b exp 100", {v, h, r}); end
    tests_run++;
    if (np !== 1) begin tests_failed++; $display("FAIL t1_held_single got %0d pulses exp 1", np); end
    tests_run++;
    if (LASTCOORD !== 6'd9 || SHOTCOUNT !== 7'd1 || HITCOUNT !== 7'd0) begin
      tests_failed++; $display("FAIL t1_counts got last=%0d shots=%0d hits=%0d exp 9/1/0", LASTCOORD, SHOTCOUNT, HITCOUNT);
    end
    release_btn();
  endtask

  task automatic test_glitch();
    int np = 0;
    @(negedge CLK);
    COORD = 6'd30;
    FIREBTN = 1'b1;
    repeat (2) @(negedge CLK);
    FIREBTN = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge CLK); #1;
      if (SHOTVALID || SHOTREPEAT || SHOTHIT) np++;
    end
    tests_run++;
    if (np !== 0) begin tests_failed++; $display("FAIL t2_glitch_pulses got %0d exp 0", np); end
    tests_run++;
    if (STATE_DBG !== ST_IDLE) begin tests_failed++; $display("FAIL t2_state got %0d exp %0d", STATE_DBG, ST_IDLE); end
    tests_run++;
    if (SHOTCOUNT !== 7'd1 || LASTCOORD !== 6'd9) begin
      tests_failed++; $display("FAIL t2_counts got shots=%0d last=%0d exp 1/9", SHOTCOUNT, LASTCOORD);
    end
  endtask

  task automatic test_repeat();
    logic v, h, r; int lat, np;
    fire_obs(6'd9, v, h, r, lat, np);
    tests_run++;
    if ({v, h, r} !== 3'b001 || lat !== 6) begin
      tests_failed++; $display("FAIL t3_repeat got v/h/r=%b lat=%0d exp 001 lat=6", {v, h, r}, lat);
    end
    tests_run++;
    if (SHOTCOUNT !== 7'd1 || LASTCOORD !== 6'd9) begin
      tests_failed++; $display("FAIL t3_counts got shots=%0d last=%0d exp 1/9", SHOTCOUNT, LASTCOORD);
    end
    release_btn();
    fire_obs(6'd20, v, h, r, lat, np);
    tests_run++;
    if ({v, h, r} !== 3'b100 || SHOTCOUNT !== 7'd2 || LASTCOORD !== 6'd20) begin
      tests_failed++; $display("FAIL t3_new_after_repeat got v/h/r=%b shots=%0d last=%0d exp 100/2/20", {v, h, r}, SHOTCOUNT, LASTCOORD);
    end
    release_btn();
  endtask

  task automatic test_win();
    logic v, h, r; int lat, np;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fire_obs(6'(i), v, h, r, lat, np);
      tests_run++;
      if ({v, h, r} !== 3'b110 || HITCOUNT !== 7'(i + 1)) begin
        tests_failed++; $display("FAIL t4_hit%0d got v/h/r=%b hits=%0d exp 110/%0d", i, {v, h, r}, HITCOUNT, i + 1);
      end
      tests_run++;
      if (GAMEOVER !== (i == 3) || WIN !== (i == 3)) begin
        tests_failed++; $display("FAIL t4_over%0d got over=%b win=%b exp %b", i, GAMEOVER, WIN, (i == 3));
      end
      release_btn();
    end
    tests_run++;
    if (STATE_DBG !== ST_DONE) begin tests_failed++; $display("FAIL t4_state got %0d exp %0d", STATE_DBG, ST_DONE); end
    fire_obs(6'd10, v, h, r, lat, np);
    tests_run++;
    if (np !== 0) begin tests_failed++; $display("FAIL t4_done_ignores got %0d pulses exp 0", np); end
    tests_run++;
    if (SHOTCOUNT !== 7'd4 || LASTCOORD !== 6'd3 || GAMEOVER !== 1'b1 || WIN !== 1'b1) begin
      tests_failed++; $display("FAIL t4_held got shots=%0d last=%0d over=%b win=%b exp 4/3/1/1", SHOTCOUNT, LASTCOORD, GAMEOVER, WIN);
    end
    release_btn();
  endtask

  task automatic test_shot_limit();
    logic v, h, r; int lat, np;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fire_obs(6'(10 + i), v, h, r, lat, np);
      tests_run++;
      if ({v, h, r} !== 3'b100) begin
        tests_failed++; $display("FAIL t5_miss%0d got v/h/r=%b exp 100", i, {v, h, r});
      end
      release_btn();
    end
    tests_run++;
    if (SHOTCOUNT !== 7'd3 || HITCOUNT !== 7'd0 || LASTCOORD !== 6'd12) begin
      tests_failed++; $display("FAIL t5_counts got shots=%0d hits=%0d last=%0d exp 3/0/12", SHOTCOUNT, HITCOUNT, LASTCOORD);
    end
`ifdef SHOT_LIMIT_EN
    tests_run++;
    if (GAMEOVER !== 1'b1 || WIN !== 1'b0) begin
      tests_failed++; $display("FAIL t5_limit got over=%b win=%b exp 1/0", GAMEOVER, WIN);
    end
`else
    tests_run++;
    if (GAMEOVER !== 1'b0 || WIN !== 1'b0) begin
      tests_failed++; $display("FAIL t5_nolimit got over=%b win=%b exp 0/0", GAMEOVER, WIN);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    logic v, h, r; int lat, np;
    do_reset();
    fire_obs(6'd0, v, h, r, lat, np);
    release_btn();
    // Reset while debouncing the next press
    @(negedge CLK);
    COORD = 6'd5;
    FIREBTN = 1'b1;
    repeat (4) @(posedge CLK);
    tests_run++;
    #1;
    if (STATE_DBG !== ST_PRESS) begin tests_failed++; $display("FAIL t6_in_press got %0d exp %0d", STATE_DBG, ST_PRESS); end
    #2;
    RST = 1'b1;
    FIREBTN = 1'b0;
    #1;
    tests_run++;
    if (SHOTCOUNT !== 7'd0 || HITCOUNT !== 7'd0 || LASTCOORD !== 6'd0 || STATE_DBG !== ST_IDLE) begin
      tests_failed++; $display("FAIL t6_rst_press got shots=%0d hits=%0d last=%0d st=%0d exp 0/0/0/0", SHOTCOUNT, HITCOUNT, LASTCOORD, STATE_DBG);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    // Reset while the report pulse is high
    COORD = 6'd7;
    FIREBTN = 1'b1;
    repeat (7) @(posedge CLK);
    #1;
    tests_run++;
    if (SHOTVALID !== 1'b1) begin tests_failed++; $display("FAIL t6_pulse_up got %b exp 1", SHOTVALID); end
    #2;
    RST = 1'b1;
    FIREBTN = 1'b0;
    #1;
    tests_run++;
    if (SHOTVALID !== 1'b0 || SHOTCOUNT !== 7'd0 || LASTCOORD !== 6'd0) begin
      tests_failed++; $display("FAIL t6_rst_report got valid=%b shots=%0d last=%0d exp 0/0/0", SHOTVALID, SHOTCOUNT, LASTCOORD);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    fire_obs(6'd7, v, h, r, lat, np);
    tests_run++;
    if ({v, h, r} !== 3'b100) begin tests_failed++; $display("FAIL t6_refire7 got v/h/r=%b exp 100", {v, h, r}); end
    release_btn();
    fire_obs(6'd0, v, h, r, lat, np);
    tests_run++;
    if ({v, h, r} !== 3'b110 || SHOTCOUNT !== 7'd2 || HITCOUNT !== 7'd1) begin
      tests_failed++; $display("FAIL t6_refire0 got v/h/r=%b shots=%0d hits=%0d exp 110/2/1", {v, h, r}, SHOTCOUNT, HITCOUNT);
    end
    release_btn();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_first_shot();
    test_glitch();
    test_repeat();
`ifndef SHOT_LIMIT_EN
    // The three-shot budget would end this four-shot game early.
    test_win();
`endif
    test_shot_limit();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/attack_commit_ctrl.md
Name: attack_commit_ctrl

Overview:
Attack-entry controller that feeds the last-valid-coordinate register. It debounces the raw fire button and captures the 6-bit switch coordinate. It rejects repeat attacks using a 64-cell attacked-history bitmap, resolves hit/miss against a fixed ship map, and tracks shots, hits and game end. Its LASTCOORD/SHOTVALID outputs are the committed-attack stream that the match/repeat-display logic consumes.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized-stable cycles needed to accept a press or a release (legal range 2..255).
SHIP_MAP, 64'h0000_0000_0000_000F, bit i = 1 means cell i holds a ship segment.
SHIP_CELLS, 4, number of hits that wins; must equal popcount(SHIP_MAP).
MAX_SHOTS, 20, valid-shot budget (used only with SHOT_LIMIT_EN), range 1..127.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
COORD  input  6  switch coordinate; row = COORD[5:3], col = COORD[2:0], cell index = COORD
FIREBTN  input  1  raw fire button, active-high, asynchronous to CLK
SHOTVALID  output  1  one-cycle pulse: new (non-repeat) shot committed
SHOTHIT  output  1  one-cycle pulse, coincident with SHOTVALID, when the committed cell is a ship
SHOTREPEAT  output  1  one-cycle pulse: the attempted cell was already attacked
LASTCOORD  output  6  coordinate of the last committed valid shot
SHOTCOUNT  output  7  number of valid shots
HITCOUNT  output  7  number of hits
GAMEOVER  output  1  level; game finished
WIN  output  1  level; meaningful only while GAMEOVER = 1

Behaviour:
- Reset (async, RST = 1): all outputs 0, bitmap cleared, synchronizer cleared, debounce counter 0, FSM = IDLE. A pulse in flight is dropped immediately.
- FIREBTN passes through a 2-flop synchronizer (fs). Edge 0 is the first rising edge that samples FIREBTN = 1. fs is first seen by the FSM at edge 2.
- FSM states: IDLE, PRESS, CHECK, REPORT, RELEASE, DONE.
- IDLE: fs = 1 -> PRESS, cnt = 1.
- PRESS: fs = 0 -> IDLE (glitch rejected, no outputs). If fs = 1 and cnt = DEBOUNCE_CYCLES-1 -> CHECK, and COORD is captured into an internal latch on that edge. Otherwise cnt++.
- CHECK (1 cycle): index the bitmap and SHIP_MAP with the latched coordinate. On the edge -> REPORT, register the results:
  - Repeat (bitmap bit = 1): SHOTREPEAT = 1. Counts, LASTCOORD and bitmap are unchanged.
  - New shot: set the bitmap bit, SHOTVALID = 1, LASTCOORD = latch, SHOTCOUNT++. If it is a ship cell, SHOTHIT = 1 and HITCOUNT++.
- REPORT (1 cycle): pulses high for exactly this cycle, i.e. the cycle after edge DEBOUNCE_CYCLES+2. Next state is DONE if the end condition is met, else RELEASE.
- End condition, evaluated on the updated counts:
  - HITCOUNT = SHIP_CELLS -> GAMEOVER = 1, WIN = 1.
  - Otherwise, shot limit reached (see Optional Feature) -> GAMEOVER = 1, WIN = 0.
  - Win has priority when both happen on the same shot.
- RELEASE: requires fs = 0 for DEBOUNCE_CYCLES consecutive cycles, then -> IDLE. Any fs = 1 restarts the count. A held button therefore never fires twice.
- DONE: absorbing until RST. FIREBTN is ignored and all counters, LASTCOORD and levels are held.
- COORD changes during PRESS/CHECK/REPORT have no effect after capture.
- Counters never wrap: HITCOUNT ≤ SHIP_CELLS by construction, and SHOTCOUNT saturates at 127.
- SHOTVALID, SHOTHIT and SHOTREPEAT are registered outputs (glitch-free). SHOTREPEAT and SHOTVALID are never high together.

Optional Feature:
SHOT_LIMIT_EN.
- Defined: reaching SHOTCOUNT = MAX_SHOTS without winning sets GAMEOVER = 1, WIN = 0, and the FSM enters DONE after REPORT.
- Undefined: there is no shot budget and MAX_SHOTS is unused. The game ends only on win. At most 64 valid shots can occur (bitmap full); further presses report SHOTREPEAT only.

Test Plan:
1. Reset, COORD = 6'd9, FIREBTN = 1 held from edge 0 (default params) -> SHOTVALID = 1, SHOTHIT = 0 during the cycle after edge 6; LASTCOORD = 9, SHOTCOUNT = 1, HITCOUNT = 0; no second pulse while the button stays held.
2. FIREBTN high for 2 cycles then low -> no pulses, FSM back in IDLE, counts unchanged (glitch rejection).
3. Fire cell 9, release ≥ 4 cycles, fire cell 9 again -> second press gives SHOTREPEAT = 1, SHOTVALID = 0, SHOTCOUNT stays 1, LASTCOORD stays 9.
4. Fire cells 0, 1, 2, 3 with proper releases -> four SHOTHIT pulses; after the 4th, HITCOUNT = 4, GAMEOVER = 1, WIN = 1; a fifth press on cell 10 produces no pulse.
5. With SHOT_LIMIT_EN and MAX_SHOTS = 3, fire misses at 10, 11, 12 -> after the 3rd, GAMEOVER = 1, WIN = 0, SHOTCOUNT = 3. Without the macro, the same sequence leaves GAMEOVER = 0.
6. Assert RST during PRESS and again during REPORT -> outputs 0 immediately, the REPORT pulse is truncated, and the bitmap is cleared (re-firing a previously hit cell yields SHOTVALID, not SHOTREPEAT).
